// File: rtl/elastic_pipe_register_if.sv
// Valid/ready bus of the elastic register chain: upstream words in, downstream words out,
// plus the flush strobe and the occupancy count.
interface elastic_pipe_register_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
);
   logic [WIDTH-1:0]               i;
   logic                           i_valid;
   logic                           i_ready;
   logic [WIDTH-1:0]               o;
   logic                           o_valid;
   logic                           o_ready;
   logic                           flush;
   logic [$clog2(DEPTH+1)-1:0]     count;

   // Side that feeds words in, consumes words out and may flush.
   modport master (
      output i, i_valid, o_ready, flush,
      input  i_ready, o, o_valid, count
   );

   // The register chain itself.
   modport slave (
      input  i, i_valid, o_ready, flush,
      output i_ready, o, o_valid, count
   );
endinterface

// File: rtl/elastic_pipe_register.sv
// DEPTH-stage elastic register chain with per-stage valid bits; empty stages keep
// accepting under back-pressure so bubbles collapse toward the output.
module elastic_pipe_register #(
   parameter int               WIDTH = 16,
   parameter int               DEPTH = 2,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic                    real_clk,
   input  logic                    reset,
   elastic_pipe_register_if.slave  bus
);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] d     [DEPTH];
   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;
   logic [DEPTH:0]   v_ext;
   logic [WIDTH-1:0] d_ext [DEPTH+1];
   logic [CW-1:0]    count_q;
   logic             in_xfer;
   logic             out_xfer;

   // A stage may load when it is empty or everything downstream of it is moving.
   always_comb begin : ready_chain
      logic r;
      // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
      r   = bus.o_ready;
      rdy = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         r      = r | ~v[k];
         rdy[k] = r;
      end
   end

   // Index k of the extended vectors is the source feeding stage k (index 0 is the input port).
   assign v_ext = {v, bus.i_valid};

   always_comb begin
      d_ext[0] = bus.i;
      for (int k = 0; k < DEPTH; k++) d_ext[k+1] = d[k];
   end

   assign bus.i_ready = rdy[0] & ~bus.flush & ~reset;
   assign bus.o_valid = v[DEPTH-1] & ~bus.flush;
   assign bus.o       = d[DEPTH-1];
   assign bus.count   = count_q;
   assign in_xfer     = bus.i_valid & bus.i_ready;
   assign out_xfer    = bus.o_valid & bus.o_ready;

   always_ff @(posedge real_clk) begin
      // NOTE: state uses non-blocking assignments so every stage samples its neighbour's old value.
      if (reset) begin
         // NOTE: the stages are individual flops, not a RAM, so loading INIT into all of them is legal.
         for (int k = 0; k < DEPTH; k++) d[k] <= INIT;
         v       <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         v       <= '0;
         count_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (rdy[k]) begin
               v[k] <= v_ext[k];
               if (v_ext[k]) d[k] <= d_ext[k];
            end
         end
         count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
      end
   end
endmodule

// File: tb/tb_elastic_pipe_register.sv
// Scoreboard bench for elastic_pipe_register: directed scenarios followed by random
// traffic, checked against an in-order queue with a minimum-latency rule.
module tb_elastic_pipe_register;
   localparam int          WIDTH = 16;
   localparam int          DEPTH = 3;
   localparam logic [15:0] INIT  = 16'hBEEF;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               ready_at;
   } word_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   elastic_pipe_register_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   elastic_pipe_register #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
      .real_clk (clk),
      .reset    (reset),
      .bus      (bus)
   );

   word_t q[$];
   int    tests = 0;
   int    fails = 0;
   int    cyc   = 0;
   bit    armed = 1'b0;
   bit    was_reset = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: words leave in acceptance order, a word observed accepted at cycle c is
   // visible at the output no earlier than c+DEPTH, and the head is visible once that
   // time has passed; occupancy is the queue length.
   always @(negedge clk) begin
      bit exp_ready;
      bit exp_ovalid;
      cyc++;
      if (armed) begin
         if (reset) begin
            check("i_ready_in_reset", 32'(bus.i_ready), 32'd0);
            q.delete();
            was_reset = 1'b1;
         end else begin
            exp_ovalid = !bus.flush && q.size() > 0 && cyc >= q[0].ready_at;
            exp_ready  = !bus.flush && (q.size() < DEPTH || bus.o_ready);
            if (was_reset) check("o_after_reset", 32'(bus.o), 32'(INIT));
            was_reset = 1'b0;
            check("count", 32'(bus.count), 32'(q.size()));
            check("i_ready", 32'(bus.i_ready), 32'(exp_ready));
            check("o_valid", 32'(bus.o_valid), 32'(exp_ovalid));
            if (exp_ovalid) check("o_data", 32'(bus.o), 32'(q[0].data));
            if (bus.flush) begin
               q.delete();
            end else begin
               if (exp_ovalid && bus.o_ready) void'(q.pop_front());
               if (bus.i_valid && exp_ready) q.push_back('{bus.i, cyc + DEPTH});
            end
         end
      end
   end

   task automatic drive(logic vld, logic [WIDTH-1:0] dat, logic ordy,
                        logic fl = 1'b0, logic rst = 1'b0);
      bus.i_valid = vld;
      bus.i       = dat;
      bus.o_ready = ordy;
      bus.flush   = fl;
      reset       = rst;
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      armed = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Streaming at full throughput.
      for (int n = 1; n <= 8; n++) drive(1'b1, 16'(n), 1'b1);
      repeat (5) drive(1'b0, '0, 1'b1);

      // Stall fill: the fourth word is refused, then everything drains in order.
      for (int n = 0; n < 4; n++) drive(1'b1, 16'hA0 + 16'(n), 1'b0);
      drive(1'b1, 16'hA3, 1'b1);
      repeat (6) drive(1'b0, '0, 1'b1);

      // Bubble collapse under a stalled output.
      drive(1'b1, 16'h11, 1'b0);
      repeat (2) drive(1'b0, '0, 1'b0);
      drive(1'b1, 16'h22, 1'b0);
      repeat (3) drive(1'b0, '0, 1'b0);
      repeat (5) drive(1'b0, '0, 1'b1);

      // Full chain with simultaneous accept and emit.
      for (int n = 5; n < 8; n++) drive(1'b1, 16'(n), 1'b0);
      drive(1'b0, '0, 1'b0);
      for (int n = 8; n < 12; n++) drive(1'b1, 16'(n), 1'b1);

      // Flush while words are held and both handshakes are offered.
      drive(1'b1, 16'hF0, 1'b1, 1'b1);
      repeat (2) drive(1'b0, '0, 1'b1);

      // Reset with two words in flight.
      drive(1'b1, 16'hC1, 1'b0);
      drive(1'b1, 16'hC2, 1'b0);
      drive(1'b1, 16'hC3, 1'b0, 1'b0, 1'b1);
      repeat (4) drive(1'b0, '0, 1'b1);

      // Random traffic with occasional flush and reset.
      for (int n = 0; n < 3000; n++)
         drive($urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 60,
               $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);

      repeat (DEPTH + 4) drive(1'b0, '0, 1'b1);
      check("drained_queue", 32'(q.size()), 32'd0);
      check("drained_count", 32'(bus.count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
